// File: rtl/decode_pkg.sv
// Shared decode constants: unit codes, branch-family opcodes/XOs, kind and state enums.
package decode_pkg;

  localparam int unsigned FX_UNIT_ID     = 0;
  localparam int unsigned BRANCH_UNIT_ID = 6;

  localparam int unsigned OP_BC = 16;
  localparam int unsigned OP_B  = 18;
  localparam int unsigned OP_XL = 19;

  localparam logic [9:0] XO_BCLR  = 10'd16;
  localparam logic [9:0] XO_BCCTR = 10'd528;

  typedef enum logic [1:0] {
    KIND_BC    = 2'd0,
    KIND_B     = 2'd1,
    KIND_BCLR  = 2'd2,
    KIND_BCCTR = 2'd3
  } branch_kind_t;

  typedef enum logic {
    IDLE = 1'b0,
    LINK = 1'b1
  } dec_state_t;

endpackage

// File: rtl/branch_classifier.sv
// Combinational classifier for the branch family: kind, legality, CTR decrement, link request.
module branch_classifier
  import decode_pkg::*;
#(
  parameter int unsigned opcodeSize = 6
) (
  input  logic [opcodeSize-1:0] opcode,
  input  logic [9:0]            xo,
  input  logic                  bo2,
  input  logic                  lk,
  output logic [1:0]            kind,
  output logic                  legal,
  output logic                  ctr_decrement,
  output logic                  needs_link
);

  branch_kind_t kind_c;

  always_comb begin
    kind_c        = KIND_BC;
    legal         = 1'b0;
    ctr_decrement = 1'b0;
    if (opcode == opcodeSize'(OP_BC)) begin
      kind_c        = KIND_BC;
      legal         = 1'b1;
      ctr_decrement = !bo2;
    end else if (opcode == opcodeSize'(OP_B)) begin
      kind_c = KIND_B;
      legal  = 1'b1;
    end else if (opcode == opcodeSize'(OP_XL)) begin
      if (xo == XO_BCLR) begin
        kind_c        = KIND_BCLR;
        legal         = 1'b1;
        ctr_decrement = !bo2;
      end else if (xo == XO_BCCTR) begin
        // bcctr with a decrementing BO is architecturally invalid
        kind_c = KIND_BCCTR;
        legal  = bo2;
      end
    end
  end

  assign kind       = kind_c;
  assign needs_link = lk;

endmodule

// File: rtl/branch_family_decoder.sv
// Branch-family decoder with valid/ready handshake and optional LR-write micro-op split.
module branch_family_decoder
  import decode_pkg::*;
#(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned instMinIdWidth          = 7,
  parameter int unsigned opcodeSize              = 6,
  parameter int unsigned funcUnitCodeSize        = 3,
  parameter int unsigned BranchUnitID            = BRANCH_UNIT_ID,
  parameter int unsigned FXUnitId                = FX_UNIT_ID,
  parameter bit          SplitLink               = 1'b1
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [opcodeSize-1:0]              instructionOpcode_i,
  input  logic [0:instructionWidth-1]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [opcodeSize-1:0]              instructionOpcode_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [1:0]                         branchKind_o,
  output logic                               ctrDecrement_o,
  output logic                               isLinkUop_o,
  output logic [25:0]                        instructionBody_o,
  output logic                               invalid_o
);

  dec_state_t state_q, state_d;
  logic       valid_d, invalid_d, load_uop0, load_uop1, accept;
  logic [1:0] kind;
  logic       legal, ctr_decrement, needs_link;
  logic       unused_opcode_field;

  // Primary opcode arrives separately; the raw copy in bits 0:5 is not needed.
  assign unused_opcode_field = ^instruction_i[0:5];

  branch_classifier #(
    .opcodeSize(opcodeSize)
  ) u_classifier (
    .opcode       (instructionOpcode_i),
    .xo           (instruction_i[21:30]),
    .bo2          (instruction_i[8]),
    .lk           (instruction_i[31]),
    .kind         (kind),
    .legal        (legal),
    .ctr_decrement(ctr_decrement),
    .needs_link   (needs_link)
  );

  assign ready_o = (state_q == IDLE) && (!valid_o || ready_i);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_o;
    invalid_d = 1'b0;
    load_uop0 = 1'b0;
    load_uop1 = 1'b0;
    if (accept) begin
      if (legal) begin
        load_uop0 = 1'b1;
        valid_d   = 1'b1;
        if (SplitLink && needs_link) state_d = LINK;
      end else begin
        valid_d   = 1'b0;
        invalid_d = 1'b1;
      end
    end else if (valid_o && ready_i) begin
      if (state_q == LINK) begin
        // Link micro-op reuses the registered fields of micro-op 0.
        load_uop1 = 1'b1;
        state_d   = IDLE;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q              <= IDLE;
      valid_o              <= 1'b0;
      invalid_o            <= 1'b0;
      instructionOpcode_o  <= '0;
      instructionAddress_o <= '0;
      functionalUnitType_o <= '0;
      instMajId_o          <= '0;
      instMinId_o          <= '0;
      is64Bit_o            <= 1'b0;
      instPid_o            <= '0;
      instTid_o            <= '0;
      branchKind_o         <= '0;
      ctrDecrement_o       <= 1'b0;
      isLinkUop_o          <= 1'b0;
      instructionBody_o    <= '0;
    end else begin
      state_q   <= state_d;
      valid_o   <= valid_d;
      invalid_o <= invalid_d;
      if (load_uop0) begin
        instructionOpcode_o  <= instructionOpcode_i;
        instructionAddress_o <= instructionAddress_i;
        functionalUnitType_o <= funcUnitCodeSize'(BranchUnitID);
        instMajId_o          <= instructionMajId_i;
        instMinId_o          <= '0;
        is64Bit_o            <= is64Bit_i;
        instPid_o            <= instructionPid_i;
        instTid_o            <= instructionTid_i;
        branchKind_o         <= kind;
        ctrDecrement_o       <= ctr_decrement;
        isLinkUop_o          <= 1'b0;
        instructionBody_o    <= instruction_i[6:31];
      end else if (load_uop1) begin
        functionalUnitType_o <= funcUnitCodeSize'(FXUnitId);
        instMinId_o          <= instMinIdWidth'(1);
        isLinkUop_o          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_family_decoder.sv
// Bench for branch_family_decoder: directed scenarios plus random traffic against a micro-op queue model.
module tb_branch_family_decoder;

  logic        clk = 1'b0;
  logic        reset_i, valid_i, ready_i;
  logic        ready_o, valid_o, invalid_o;
  logic [5:0]  op_i;
  logic [31:0] instr_i;
  logic [63:0] addr_i, maj_i;
  logic        is64_i;
  logic [19:0] pid_i;
  logic [15:0] tid_i;
  logic [5:0]  op_o;
  logic [63:0] addr_o, maj_o;
  logic [2:0]  unit_o;
  logic [6:0]  minid_o;
  logic        is64_o, ctr_o, link_o;
  logic [19:0] pid_o;
  logic [15:0] tid_o;
  logic [1:0]  kind_o;
  logic [25:0] body_o;

  always #5 clk = ~clk;

  branch_family_decoder dut (
    .clock_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .instructionOpcode_i(op_i), .instruction_i(instr_i), .instructionAddress_i(addr_i),
    .is64Bit_i(is64_i), .instructionPid_i(pid_i), .instructionTid_i(tid_i),
    .instructionMajId_i(maj_i), .valid_o(valid_o), .ready_i(ready_i),
    .instructionOpcode_o(op_o), .instructionAddress_o(addr_o),
    .functionalUnitType_o(unit_o), .instMajId_o(maj_o), .instMinId_o(minid_o),
    .is64Bit_o(is64_o), .instPid_o(pid_o), .instTid_o(tid_o), .branchKind_o(kind_o),
    .ctrDecrement_o(ctr_o), .isLinkUop_o(link_o), .instructionBody_o(body_o),
    .invalid_o(invalid_o)
  );

  typedef struct {
    logic [5:0]  op;
    logic [63:0] addr;
    logic [2:0]  unit;
    logic [63:0] maj;
    logic [6:0]  minid;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [1:0]  kind;
    logic        ctr;
    logic        link;
    logic [25:0] body;
  } uop_t;

  uop_t        q[$];
  logic        exp_inv = 1'b0;
  logic        last_accept;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] maj_ctr = 64'h100;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen(input int t, input int lk);
    logic [31:0] w;
    logic [5:0]  op;
    w = $urandom;
    case (t)
      0: op = 6'd16;
      1: op = 6'd18;
      2: begin op = 6'd19; w[10:1] = 10'd16; end
      3: begin op = 6'd19; w[10:1] = 10'd528; w[23] = 1'b1; end
      4: begin op = 6'd19; w[10:1] = 10'd528; w[23] = 1'b0; end
      5: op = 6'd17;
      default: begin op = 6'd19; w[10:1] = 10'd100; end
    endcase
    if (lk < 2) w[0] = lk[0];
    w[31:26] = op;
    op_i    = op;
    instr_i = w;
    addr_i  = {$urandom, $urandom};
    maj_i   = maj_ctr;
    maj_ctr = maj_ctr + 1;
    pid_i   = 20'($urandom);
    tid_i   = 16'($urandom);
    is64_i  = 1'($urandom);
  endtask

  // One clock: drive, check ready_o, advance the transaction-level model, check outputs.
  task automatic step(input logic v, input logic rdy, input logic rst);
    logic  model_ready, legal, do_accept;
    int    xo, lk, bo2, kind, ctr;
    uop_t  u;
    @(negedge clk);
    valid_i = v; ready_i = rdy; reset_i = rst;
    #1;
    model_ready = (q.size() == 0) || (q.size() == 1 && rdy);
    if (!rst) chk("ready_o", ready_o, model_ready);
    do_accept = !rst && v && model_ready;
    @(posedge clk);
    last_accept = do_accept;
    exp_inv = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (do_accept) begin
        xo  = int'((instr_i >> 1) & 32'h3FF);
        lk  = int'(instr_i & 32'h1);
        bo2 = int'((instr_i >> 23) & 32'h1);
        legal = 1'b1; kind = 0; ctr = 0;
        if (op_i == 16)                  begin kind = 0; ctr = 1 - bo2; end
        else if (op_i == 18)             begin kind = 1; ctr = 0; end
        else if (op_i == 19 && xo == 16) begin kind = 2; ctr = 1 - bo2; end
        else if (op_i == 19 && xo == 528) begin kind = 3; ctr = 0; legal = (bo2 == 1); end
        else legal = 1'b0;
        if (legal) begin
          u.op = op_i; u.addr = addr_i; u.unit = 3'd6; u.maj = maj_i; u.minid = 7'd0;
          u.is64 = is64_i; u.pid = pid_i; u.tid = tid_i; u.kind = 2'(kind);
          u.ctr = ctr[0]; u.link = 1'b0; u.body = 26'(instr_i % (32'd1 << 26));
          q.push_back(u);
          if (lk == 1) begin
            u.unit = 3'd0; u.minid = 7'd1; u.link = 1'b1;
            q.push_back(u);
          end
        end else begin
          exp_inv = 1'b1;
        end
      end
    end
    #1;
    chk("valid_o", valid_o, q.size() != 0);
    chk("invalid_o", invalid_o, exp_inv);
    if (q.size() != 0) begin
      chk("unit", unit_o, q[0].unit);
      chk("minid", minid_o, q[0].minid);
      chk("islink", link_o, q[0].link);
      chk("kind", kind_o, q[0].kind);
      chk("ctrdec", ctr_o, q[0].ctr);
      chk("body", body_o, q[0].body);
      chk("majid", maj_o, q[0].maj);
      chk("addr", addr_o, q[0].addr);
      chk("pass", {op_o, is64_o, pid_o, tid_o}, {q[0].op, q[0].is64, q[0].pid, q[0].tid});
    end
  endtask

  initial begin
    logic offering;
    valid_i = 0; ready_i = 0; reset_i = 1;
    gen(0, 0);

    // Reset state: no valid, all data outputs zero.
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_data", {op_o, addr_o, unit_o, maj_o, minid_o, is64_o, pid_o, tid_o, kind_o, ctr_o, link_o},
        128'd0);
    chk("rst_body", body_o, 26'd0);

    // bc, BO=01100 (BO_2=1), LK=0.
    gen(0, 0);
    instr_i[25:21] = 5'b01100;
    step(1, 1, 0);
    chk("t1_ctr", ctr_o, 1'b0);
    chk("t1_unit", unit_o, 3'd6);
    step(0, 1, 0);

    // b with LK=1: two micro-ops, ready_o low while the link op is pending.
    gen(1, 1);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("t2_link", {unit_o, minid_o, link_o}, {3'd0, 7'd1, 1'b1});
    step(0, 1, 0);

    // bclr stalled for 3 cycles, then the next instruction is taken on release.
    gen(2, 0);
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    gen(0, 0);
    step(1, 1, 0);
    chk("t3_accept", last_accept, 1'b1);
    step(0, 1, 0);

    // Illegal: bcctr with BO_2=0, opcode 17, bad XO.
    gen(4, 2); step(1, 1, 0); step(0, 1, 0);
    gen(5, 2); step(1, 1, 0); step(0, 1, 0);
    gen(6, 2); step(1, 1, 0); step(0, 1, 0);

    // Reset while the link micro-op is pending.
    gen(0, 1);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);

    // Ten back-to-back non-link bc.
    for (int i = 0; i < 10; i++) begin
      gen(0, 0);
      step(1, 1, 0);
    end
    step(0, 1, 0);

    // Random traffic; an offered instruction is held until accepted.
    offering = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!offering) begin
        offering = ($urandom_range(0, 2) != 0);
        if (offering) gen($urandom_range(0, 6), 2);
      end
      step(offering, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      if (last_accept) offering = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_family_decoder.md
Name: branch_family_decoder

Overview:
- Parametrised successor to the single-format B-form decoder in Decode stage 2.
- Decodes the whole branch family: B-form bc (opcode 16), I-form b (opcode 18), and XL-form bclr/bcctr (opcode 19, XO 16/528).
- Adds a valid/ready handshake on both sides and optional link micro-op splitting: LK=1 emits a second micro-op that writes LR on the FX unit.
- Sits between the format decoder and the dispatch queue.

Parameters:
addressWidth, 64, instruction address width
instructionWidth, 32, fixed instruction width
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major ID width
instMinIdWidth, 7, minor ID width
opcodeSize, 6, primary opcode width
funcUnitCodeSize, 3, functional unit code width
BranchUnitID, 6, branch unit code
FXUnitId, 0, integer unit code
SplitLink, 1, 1 = LK=1 generates an LR-write micro-op; 0 = single micro-op carrying LK

Ports:
clock_i  in  1  clock
reset_i  in  1  synchronous active-high reset
valid_i  in  1  upstream instruction valid
ready_o  out  1  decoder can accept this cycle
instructionOpcode_i  in  opcodeSize  primary opcode
instruction_i  in  instructionWidth  raw instruction, bit 0 = MSB
instructionAddress_i  in  addressWidth  instruction address
is64Bit_i  in  1  64-bit mode
instructionPid_i  in  PidSize  process ID
instructionTid_i  in  TidSize  thread ID
instructionMajId_i  in  instructionCounterWidth  major ID
valid_o  out  1  micro-op valid
ready_i  in  1  downstream accepts micro-op
instructionOpcode_o  out  opcodeSize  opcode
instructionAddress_o  out  addressWidth  address
functionalUnitType_o  out  funcUnitCodeSize  target unit
instMajId_o  out  instructionCounterWidth  major ID
instMinId_o  out  instMinIdWidth  minor ID
is64Bit_o, instPid_o, instTid_o  out  1/PidSize/TidSize  passthrough
branchKind_o  out  2  0=bc 1=b 2=bclr 3=bcctr
ctrDecrement_o  out  1  branch decrements CTR
isLinkUop_o  out  1  micro-op is the LR write
instructionBody_o  out  26  instruction bits [6:31] verbatim
invalid_o  out  1  one-cycle pulse: dropped illegal instruction

Behaviour:
- Reset (synchronous, reset_i high at clock edge):
  - valid_o=0, invalid_o=0, state=IDLE.
  - All data outputs = 0.
  - Reset mid-LINK discards the pending link micro-op.
- States: IDLE, LINK.
- Handshake:
  - ready_o = (state==IDLE) && (!valid_o || ready_i).
  - Accept happens when valid_i && ready_o.
  - Output holds stable while valid_o && !ready_i.
- Accept of a legal instruction:
  - Next cycle valid_o=1 with micro-op 0: instMinId_o=0, functionalUnitType_o=BranchUnitID, isLinkUop_o=0. Latency is 1 cycle.
  - If SplitLink && LK (bit 31)=1, go to LINK.
- LINK:
  - When valid_o && ready_i, load micro-op 1: instMinId_o=1, functionalUnitType_o=FXUnitId, isLinkUop_o=1, same major ID, address, body, PID and TID. Then go to IDLE.
  - No new input is accepted in LINK.
- Classification:
  - opcode 16 → kind 0.
  - opcode 18 → kind 1; ctrDecrement_o=0.
  - opcode 19 with XO (bits 21:30)=16 → kind 2.
  - opcode 19 with XO=528 → kind 3.
- ctrDecrement_o: for kinds 0 and 2 it equals !instruction_i[8] (BO_2 = 0 means decrement). For kind 3 it is 0.
- Illegal inputs: any other opcode/XO, or bcctr with BO_2=0.
  - The instruction is still accepted.
  - No micro-op is produced; valid_o drops to 0 if the previous micro-op was consumed.
  - invalid_o=1 for exactly one cycle.
- Back-to-back, non-link instructions: sustains 1 instruction/cycle while ready_i=1.
- Link-split instructions cost 2 cycles each.
- valid_i while ready_o=0: not consumed, no side effects; upstream must hold it.

Decomposition:
- Shared package decode_pkg holds:
  - Functional unit IDs: FXUnitId, BranchUnitID.
  - Opcode constants: OP_BC=16, OP_B=18, OP_XL=19.
  - XO constants: XO_BCLR=16, XO_BCCTR=528.
  - branchKind enum.
  - Decoder state enum.
- One natural sub-module: branch_classifier. It is combinational, taking opcode and instruction and returning kind, legal, ctrDecrement and needsLink. The FSM and output register stay in the top module.

Test Plan:
1. bc opcode 16, BO=01100 (bit 8=1), LK=0, ready_i=1 → one cycle later: valid_o=1, kind 0, ctrDecrement_o=0, minId 0, unit 6, body = inst[6:31].
2. b opcode 18, LK=1, SplitLink=1, ready_i=1 → micro-op 0 (unit 6, minId 0), then next cycle micro-op 1 (unit 0, minId 1, isLinkUop_o=1); ready_o=0 during LINK.
3. bclr XO=16 with ready_i held 0 for 3 cycles → outputs stable, ready_o=0; release ready_i → the next queued input is accepted the same cycle.
4. bcctr XO=528 with BO_2=0 → no valid_o, invalid_o=1 for one cycle; an opcode-17 instruction behaves the same.
5. reset_i asserted while in LINK → valid_o=0, state IDLE next cycle, no link micro-op is emitted afterwards.
6. Ten back-to-back non-link bc with ready_i=1 → ten valid_o cycles, contiguous, in order, major IDs preserved.
